// File: rtl/ysyx_22050854_ctrl_pkg.sv
// Shared encodings for the NPC multi-cycle sequencer: state codes, IDU Branch codes
// and the default response-wait limit.
package ysyx_22050854_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IF_REQ   = 3'd1,
    S_IF_WAIT  = 3'd2,
    S_EX       = 3'd3,
    S_MEM_REQ  = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_WB       = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam int         BR_COND = 2;

  localparam int TIMEOUT_DEF = 16;

  // Unconditional jumps always redirect; conditional branches only when the ALU says so.
  function automatic logic take_target(input logic [2:0] br, input logic taken);
    return (br == BR_JAL) || (br == BR_JALR) || (br[BR_COND] && taken);
  endfunction

  function automatic logic is_wait(input state_t s);
    return (s == S_IF_WAIT) || (s == S_MEM_WAIT);
  endfunction

endpackage

// File: rtl/ysyx_22050854_timeout_cnt.sv
// Response-wait watchdog: counts cycles while enabled, flags the last allowed cycle.
// Combinational expired, one-cycle clear; no handshake of its own.
module ysyx_22050854_timeout_cnt #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // First waiting cycle sees cnt=0, so the TIMEOUT-th waiting cycle sees LIMIT.
  assign expired = enable && (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_22050854_ctrl_fsm.sv
// NPC multi-cycle sequencer: fetch, execute, optional memory, writeback (4 / 6 cycles min).
// Requests are held until ready; response waits are bounded and end in a sticky error halt.
module ysyx_22050854_ctrl_fsm
  import ysyx_22050854_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  output logic        ir_wen,
  input  logic        RegWr,
  input  logic        MemtoReg,
  input  logic        MemWr,
  input  logic [2:0]  Branch,
  input  logic        ebreak,
  input  logic        br_taken,
  output logic        dmem_req_valid,
  output logic        dmem_req_we,
  input  logic        dmem_req_ready,
  input  logic        dmem_rsp_valid,
  output logic        rf_wen,
  output logic        pc_wen,
  output logic        pc_sel,
  output logic        halt,
  output logic        err,
  output logic [2:0]  state,
  output logic [63:0] instret
);

  state_t cur;
  logic   waiting;
  logic   expired;

  assign waiting = is_wait(cur);

  // One watchdog serves both wait states; it is held clear everywhere else.
  ysyx_22050854_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!waiting),
    .enable  (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= S_IDLE;
      instret <= '0;
      err     <= 1'b0;
    end else begin
      case (cur)
        S_IDLE: cur <= S_IF_REQ;
        S_IF_REQ: begin
          if (imem_req_ready) cur <= S_IF_WAIT;
        end
        S_IF_WAIT: begin
          // A response on the limit cycle still wins over the timeout.
          if (imem_rsp_valid) begin
            cur <= S_EX;
          end else if (expired) begin
            err <= 1'b1;
            cur <= S_HALT;
          end
        end
        S_EX: begin
          if (ebreak) begin
            instret <= instret + 64'd1;
            cur     <= S_HALT;
          end else if (MemtoReg || MemWr) begin
            cur <= S_MEM_REQ;
          end else begin
            cur <= S_WB;
          end
        end
        S_MEM_REQ: begin
          if (dmem_req_ready) cur <= S_MEM_WAIT;
        end
        S_MEM_WAIT: begin
          if (dmem_rsp_valid) begin
            cur <= S_WB;
          end else if (expired) begin
            err <= 1'b1;
            cur <= S_HALT;
          end
        end
        S_WB: begin
          instret <= instret + 64'd1;
          cur     <= S_IF_REQ;
        end
        S_HALT: cur <= S_HALT;
      endcase
    end
  end

  // Everything below decodes the state register, so an async reset kills it at once.
  assign state          = cur;
  assign imem_req_valid = (cur == S_IF_REQ);
  assign ir_wen         = (cur == S_IF_WAIT) && imem_rsp_valid;
  assign dmem_req_valid = (cur == S_MEM_REQ);
  assign dmem_req_we    = (cur == S_MEM_REQ) && MemWr;
  assign rf_wen         = (cur == S_WB) && RegWr;
  assign pc_wen         = (cur == S_WB);
  assign pc_sel         = (cur == S_WB) && take_target(Branch, br_taken);
  assign halt           = (cur == S_HALT);

endmodule

// File: tb/tb_ysyx_22050854_ctrl_fsm.sv
// Directed bench for the NPC sequencer: per-cycle vector table plus timeout and reset sequences.
module tb_ysyx_22050854_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, ir_wen;
  logic        RegWr, MemtoReg, MemWr, ebreak, br_taken;
  logic [2:0]  Branch;
  logic        dmem_req_valid, dmem_req_we, dmem_req_ready, dmem_rsp_valid;
  logic        rf_wen, pc_wen, pc_sel, halt, err;
  logic [2:0]  state;
  logic [63:0] instret;

  int total = 0;
  int bad   = 0;

  ysyx_22050854_ctrl_fsm #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .ir_wen         (ir_wen),
    .RegWr          (RegWr),
    .MemtoReg       (MemtoReg),
    .MemWr          (MemWr),
    .Branch         (Branch),
    .ebreak         (ebreak),
    .br_taken       (br_taken),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_ready (dmem_req_ready),
    .dmem_rsp_valid (dmem_rsp_valid),
    .rf_wen         (rf_wen),
    .pc_wen         (pc_wen),
    .pc_sel         (pc_sel),
    .halt           (halt),
    .err            (err),
    .state          (state),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  // IDU patterns: {RegWr, MemtoReg, MemWr, Branch[2:0], ebreak}
  localparam logic [6:0] I_ADDI = 7'b1_0_0_000_0;
  localparam logic [6:0] I_SD   = 7'b0_0_1_000_0;
  localparam logic [6:0] I_LW   = 7'b1_1_0_000_0;
  localparam logic [6:0] I_BEQ  = 7'b0_0_0_100_0;
  localparam logic [6:0] I_JALR = 7'b1_0_0_010_0;
  localparam logic [6:0] I_JAL  = 7'b1_0_0_001_0;
  localparam logic [6:0] I_EB   = 7'b0_0_0_000_1;

  // Handshake inputs: {imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid}
  localparam logic [3:0] H_IR = 4'b1000;
  localparam logic [3:0] H_IS = 4'b0100;
  localparam logic [3:0] H_DR = 4'b0010;
  localparam logic [3:0] H_DS = 4'b0001;

  // Outputs: {imem_req_valid, ir_wen, dmem_req_valid, dmem_req_we, rf_wen, pc_wen, pc_sel, halt, err}
  localparam logic [8:0] O_IMREQ = 9'b1_0000_0000;
  localparam logic [8:0] O_IRWEN = 9'b0_1000_0000;
  localparam logic [8:0] O_DREQ  = 9'b0_0100_0000;
  localparam logic [8:0] O_WE    = 9'b0_0010_0000;
  localparam logic [8:0] O_RF    = 9'b0_0001_0000;
  localparam logic [8:0] O_PC    = 9'b0_0000_1000;
  localparam logic [8:0] O_SEL   = 9'b0_0000_0100;
  localparam logic [8:0] O_HALT  = 9'b0_0000_0010;
  localparam logic [8:0] O_ERR   = 9'b0_0000_0001;

  typedef struct {
    logic [6:0]  idu;
    logic        bt;
    logic [3:0]  hs;
    logic [2:0]  st;
    logic [8:0]  o;
    logic [63:0] ir;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [8:0] outs();
    return {imem_req_valid, ir_wen, dmem_req_valid, dmem_req_we, rf_wen, pc_wen, pc_sel, halt, err};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] idu, input logic bt, input logic [3:0] hs);
    {RegWr, MemtoReg, MemWr, Branch, ebreak} = idu;
    br_taken = bt;
    {imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid} = hs;
  endtask

  task automatic add(input logic [6:0] idu, input logic bt, input logic [3:0] hs,
                     input logic [2:0] st, input logic [8:0] o, input logic [63:0] ir);
    vec_t v;
    v.idu = idu; v.bt = bt; v.hs = hs; v.st = st; v.o = o; v.ir = ir;
    tbl.push_back(v);
  endtask

  // Leaves the bench at a falling edge with rst_n just released: the DUT is in IDLE.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(7'b0, 1'b0, 4'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset outs", {61'b0, state} << 9 | {55'b0, outs()}, 64'd0);
    chk("reset instret", instret, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic timeout_run(input bit mem, input bit resp);
    logic [6:0] ins;
    logic [2:0] wst;
    logic [3:0] rsp_hs;
    ins    = mem ? I_SD : I_ADDI;
    wst    = mem ? 3'd5 : 3'd2;
    rsp_hs = mem ? H_DS : H_IS;
    do_reset();
    drive(ins, 1'b0, mem ? (H_IR | H_IS | H_DR) : H_IR);
    repeat (mem ? 5 : 2) @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      drive(ins, 1'b0, (resp && k == 16) ? rsp_hs : 4'b0);
      #1;
      chk($sformatf("tmo m%0d r%0d k%0d state", mem, resp, k), {61'b0, state}, {61'b0, wst});
      chk($sformatf("tmo m%0d r%0d k%0d err", mem, resp, k), {63'b0, err}, 64'd0);
      @(negedge clk);
    end
    drive(ins, 1'b0, 4'b0);
    #1;
    chk($sformatf("tmo m%0d r%0d end state", mem, resp), {61'b0, state},
        resp ? (mem ? 64'd6 : 64'd3) : 64'd7);
    chk($sformatf("tmo m%0d r%0d end halt/err", mem, resp), {62'b0, halt, err},
        resp ? 64'd0 : 64'd3);
  endtask

  initial begin
    // addi: zero-wait fetch, 4-cycle instruction
    add(I_ADDI, 0, 0,    3'd0, 9'd0,          0);
    add(I_ADDI, 0, H_IR, 3'd1, O_IMREQ,       0);
    add(I_ADDI, 0, H_IS, 3'd2, O_IRWEN,       0);
    add(I_ADDI, 0, 0,    3'd3, 9'd0,          0);
    add(I_ADDI, 0, 0,    3'd6, O_RF | O_PC,   0);
    // sd with data request stalled three cycles
    add(I_SD, 0, H_IR, 3'd1, O_IMREQ,        1);
    add(I_SD, 0, H_IS, 3'd2, O_IRWEN,        1);
    add(I_SD, 0, 0,    3'd3, 9'd0,           1);
    add(I_SD, 0, 0,    3'd4, O_DREQ | O_WE,  1);
    add(I_SD, 0, 0,    3'd4, O_DREQ | O_WE,  1);
    add(I_SD, 0, 0,    3'd4, O_DREQ | O_WE,  1);
    add(I_SD, 0, H_DR, 3'd4, O_DREQ | O_WE,  1);
    add(I_SD, 0, H_DS, 3'd5, 9'd0,           1);
    add(I_SD, 0, 0,    3'd6, O_PC,           1);
    // beq taken, then not taken
    add(I_BEQ, 1, H_IR, 3'd1, O_IMREQ,       2);
    add(I_BEQ, 1, H_IS, 3'd2, O_IRWEN,       2);
    add(I_BEQ, 1, 0,    3'd3, 9'd0,          2);
    add(I_BEQ, 1, 0,    3'd6, O_PC | O_SEL,  2);
    add(I_BEQ, 0, H_IR, 3'd1, O_IMREQ,       3);
    add(I_BEQ, 0, H_IS, 3'd2, O_IRWEN,       3);
    add(I_BEQ, 0, 0,    3'd3, 9'd0,          3);
    add(I_BEQ, 0, 0,    3'd6, O_PC,          3);
    // jalr
    add(I_JALR, 0, H_IR, 3'd1, O_IMREQ,             4);
    add(I_JALR, 0, H_IS, 3'd2, O_IRWEN,             4);
    add(I_JALR, 0, 0,    3'd3, 9'd0,                4);
    add(I_JALR, 0, 0,    3'd6, O_RF | O_PC | O_SEL, 4);
    // lw with fetch-ready and both response stalls; br_taken must not matter
    add(I_LW, 1, 0,    3'd1, O_IMREQ,      5);
    add(I_LW, 1, H_IR, 3'd1, O_IMREQ,      5);
    add(I_LW, 1, 0,    3'd2, 9'd0,         5);
    add(I_LW, 1, H_IS, 3'd2, O_IRWEN,      5);
    add(I_LW, 1, 0,    3'd3, 9'd0,         5);
    add(I_LW, 1, H_DR, 3'd4, O_DREQ,       5);
    add(I_LW, 1, 0,    3'd5, 9'd0,         5);
    add(I_LW, 1, H_DS, 3'd5, 9'd0,         5);
    add(I_LW, 1, 0,    3'd6, O_RF | O_PC,  5);
    // jal
    add(I_JAL, 0, H_IR, 3'd1, O_IMREQ,             6);
    add(I_JAL, 0, H_IS, 3'd2, O_IRWEN,             6);
    add(I_JAL, 0, 0,    3'd3, 9'd0,                6);
    add(I_JAL, 0, 0,    3'd6, O_RF | O_PC | O_SEL, 6);
    // ebreak retires and halts
    add(I_EB, 0, H_IR,        3'd1, O_IMREQ, 7);
    add(I_EB, 0, H_IS,        3'd2, O_IRWEN, 7);
    add(I_EB, 0, 0,           3'd3, 9'd0,    7);
    add(I_EB, 0, H_IR | H_IS, 3'd7, O_HALT,  8);

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].idu, tbl[i].bt, tbl[i].hs);
      #1;
      chk($sformatf("vec%0d state", i), {61'b0, state}, {61'b0, tbl[i].st});
      chk($sformatf("vec%0d outs", i), {55'b0, outs()}, {55'b0, tbl[i].o});
      chk($sformatf("vec%0d instret", i), instret, tbl[i].ir);
      @(negedge clk);
    end

    // HALT is sticky regardless of handshakes
    for (int k = 0; k < 20; k++) begin
      drive(I_ADDI, 1'b1, 4'b1111);
      #1;
      chk($sformatf("halt hold %0d outs", k), {52'b0, state, outs()}, {52'b0, 3'd7, O_HALT});
      chk($sformatf("halt hold %0d instret", k), instret, 64'd8);
      @(negedge clk);
    end

    timeout_run(1'b0, 1'b0);
    timeout_run(1'b0, 1'b1);
    timeout_run(1'b1, 1'b0);
    timeout_run(1'b1, 1'b1);

    // Reset in WB kills write strobes without a clock edge
    do_reset();
    drive(I_ADDI, 1'b0, H_IR | H_IS);
    repeat (4) @(negedge clk);
    #1;
    chk("wb pre-reset strobes", {62'b0, rf_wen, pc_wen}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("wb async reset", {59'b0, rf_wen, pc_wen, state}, 64'd0);

    // Reset in MEM_REQ drops the request and clears instret immediately
    do_reset();
    drive(I_ADDI, 1'b0, H_IR | H_IS);
    repeat (5) @(negedge clk);
    drive(I_SD, 1'b0, H_IR | H_IS);
    repeat (3) @(negedge clk);
    #1;
    chk("memreq pre-reset req", {59'b0, dmem_req_valid, dmem_req_we, state}, {59'b0, 2'b11, 3'd4});
    chk("memreq pre-reset instret", instret, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("memreq async reset req", {59'b0, dmem_req_valid, dmem_req_we, state}, 64'd0);
    chk("memreq async reset instret", instret, 64'd0);

    // Reset in MEM_WAIT; a late data response afterwards must be ignored
    do_reset();
    drive(I_SD, 1'b0, H_IR | H_IS | H_DR);
    repeat (5) @(negedge clk);
    #1;
    chk("memwait pre-reset state", {61'b0, state}, 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("memwait async reset", {52'b0, state, outs()}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(I_SD, 1'b0, H_DS);
    #1;
    chk("late rsp idle", {52'b0, state, outs()}, 64'd0);
    @(negedge clk);
    #1;
    chk("late rsp refetch", {52'b0, state, outs()}, {52'b0, 3'd1, O_IMREQ});
    @(negedge clk);
    #1;
    chk("late rsp still fetching", {52'b0, state, outs()}, {52'b0, 3'd1, O_IMREQ});
    chk("late rsp instret", instret, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050854_ctrl_fsm.md
Name: ysyx_22050854_ctrl_fsm

Overview:
Multi-cycle sequencer for the NPC core. It steps each instruction through fetch, execute, optional memory access and writeback, and handshakes with instruction and data memory. It consumes the IDU control outputs and drives the register-file, IR and PC write strobes. It also provides halt/error status and a retired-instruction counter for the simulation environment.

Parameters:
TIMEOUT, 16, cycles allowed in a response-wait state before error (min 2)
CNT_W, 8, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  fetch request accepted
imem_rsp_valid  in  1  instruction word valid on the datapath bus
ir_wen  out  1  latch fetched word into the IR
RegWr  in  1  IDU: instruction writes rd
MemtoReg  in  1  IDU: load
MemWr  in  1  IDU: store
Branch  in  3  IDU: 000 none, 001 jal, 010 jalr, 1xx conditional
ebreak  in  1  IDU: ebreak decoded
br_taken  in  1  ALU compare result for conditional branch
dmem_req_valid  out  1  data memory request
dmem_req_we  out  1  1 = store, 0 = load
dmem_req_ready  in  1  data request accepted
dmem_rsp_valid  in  1  load data valid / store done
rf_wen  out  1  register-file write strobe
pc_wen  out  1  PC update strobe
pc_sel  out  1  0 = pc+4, 1 = branch/jump target
halt  out  1  sticky stop
err  out  1  sticky memory timeout
state  out  3  current state, debug
instret  out  64  retired instruction count

Behaviour:
- States: IDLE=0, IF_REQ=1, IF_WAIT=2, EX=3, MEM_REQ=4, MEM_WAIT=5, WB=6, HALT=7. ERR is folded into HALT with err=1.
- Reset (async, rst_n=0): state=IDLE, instret=0, err=0, timeout counter=0. All strobes/requests are 0 immediately, including mid-transaction. An outstanding memory response after reset is ignored.
- IDLE: advance to IF_REQ on the next cycle.
- IF_REQ: imem_req_valid=1 and held until imem_req_ready. Go to IF_WAIT on the ready cycle.
- IF_WAIT:
  - On imem_rsp_valid: ir_wen=1 for that one cycle, then go to EX.
  - Timeout: the counter clears on entry and increments each waiting cycle. Count reaching TIMEOUT-1 with no response sets err=1 and goes to HALT.
  - A response in the same cycle as the limit wins; no error.
- EX: IDU outputs are valid from the registered IR. Priority:
  1. ebreak: instret+1, then HALT.
  2. MemtoReg or MemWr: go to MEM_REQ.
  3. Otherwise: go to WB.
- MEM_REQ: dmem_req_valid=1, dmem_req_we=MemWr, both held stable until dmem_req_ready. Go to MEM_WAIT.
- MEM_WAIT: on dmem_rsp_valid go to WB. Timeout is identical to IF_WAIT.
- WB, single cycle:
  - rf_wen=RegWr, pc_wen=1.
  - pc_sel = (Branch==001) | (Branch==010) | (Branch[2] & br_taken).
  - instret+1, then go to IF_REQ.
- HALT: halt=1, all strobes 0, no requests. Exits only on reset.
- Outputs are Moore functions of state, except ir_wen (state & imem_rsp_valid) and the rf_wen/pc_sel/dmem_req_we operand terms.
- Minimum latency with zero-wait memory: 4 cycles for ALU/branch/jump instructions, 6 cycles for load/store.
- instret wraps modulo 2^64.

Decomposition:
- Package ysyx_22050854_ctrl_pkg: state encodings, Branch code constants (BR_NONE, BR_JAL, BR_JALR, BR_COND bit), TIMEOUT default.
- Sub-module ysyx_22050854_timeout_cnt (clear, enable, expired), instantiated once and shared by IF_WAIT and MEM_WAIT.

Test Plan:
- Reset release, addi (RegWr=1, Branch=000), imem ready=1, response next cycle -> states 1,2,3,6; rf_wen=1 and pc_wen=1 on cycle 4 with pc_sel=0; instret=1.
- sd (MemWr=1, RegWr=0), dmem_req_ready held low 3 cycles -> dmem_req_valid=1 and we=1 stable for 4 cycles; rf_wen=0 in WB; instret+1.
- beq (Branch=100): br_taken=1 -> pc_sel=1; br_taken=0 -> pc_sel=0; jalr (010) -> pc_sel=1 and rf_wen=1.
- ebreak -> halt=1 from the next cycle and stays set for 20 cycles; imem_req_valid stays 0; instret counts the ebreak.
- TIMEOUT=16, imem never responds -> err=1 and halt=1 after 16 cycles in IF_WAIT; repeat with the response on the 16th cycle -> err=0 and EX entered.
- rst_n asserted during MEM_WAIT -> dmem_req_valid, rf_wen and pc_wen drop to 0 without a clock edge; instret=0; a late dmem_rsp_valid after release is ignored; fetch restarts via IDLE.
